// File: rtl/lz4_out_reader.sv
// Consumer end of the lz4_top output FIFO: re-emits compressed words on a
// valid/ready stream and closes every block with a count word and an XOR checksum.
module lz4_out_reader #(
    parameter int         DW        = 32,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] TRAIL_TAG = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          out_empty,
    input  logic [DW-1:0] out_data,
    input  logic          out_valid,
    output logic          out_en,
    input  logic          blk_end,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_FLUSH = 3'd2,
        ST_TRL0  = 3'd3,
        ST_TRL1  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [DW-1:0]    skid0_r;
    logic [DW-1:0]    skid1_r;
    logic [1:0]       occ_r;
    logic             inflight_r;
    logic             end_seen_r;
    logic             end_pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    sum_r;
    logic             ovf_r;
    logic             perr_r;

    logic [DW-1:0]    skid0_s;
    logic [DW-1:0]    skid1_s;
    logic [1:0]       occ_s;
    logic             drop_s;
    logic             stray_s;
    logic             payload_st_s;
    logic             room_s;
    logic             out_en_s;
    logic             m_valid_s;
    logic             m_last_s;
    logic [DW-1:0]    m_data_s;
    logic             hs_s;
    logic             pop_s;

    function automatic logic [DW-1:0] sum_fold(input logic [DW-1:0] acc,
                                               input logic [DW-1:0] word);
        return acc ^ word;
    endfunction

    // Count is presented as a 16-bit field whatever CNT_W is.
    function automatic logic [DW-1:0] trailer0(input logic perr,
                                               input logic ovf,
                                               input logic [CNT_W-1:0] cnt);
        logic [31:0] w;
        w = {TRAIL_TAG, perr, 6'b000000, ovf, 16'(cnt)};
        return DW'(w);
    endfunction

    // Stream-side view: payload from the skid head, then the two trailer words.
    always_comb begin
        payload_st_s = (state_r == ST_IDLE) || (state_r == ST_DRAIN);
        m_valid_s    = 1'b0;
        m_last_s     = 1'b0;
        m_data_s     = skid0_r;
        case (state_r)
            ST_IDLE, ST_DRAIN: begin
                m_valid_s = (occ_r != 2'd0);
            end
            ST_TRL0: begin
                m_valid_s = 1'b1;
                m_data_s  = trailer0(perr_r, ovf_r, cnt_r);
            end
            ST_TRL1: begin
                m_valid_s = 1'b1;
                m_last_s  = 1'b1;
                m_data_s  = sum_r;
            end
            default: begin
                m_valid_s = 1'b0;
                m_data_s  = skid0_r;
            end
        endcase
        hs_s    = m_valid_s && m_ready;
        pop_s   = hs_s && payload_st_s;
        stray_s = out_valid && !inflight_r;
    end

    // Pop request: never more words outstanding than the skid can hold.
    always_comb begin
        room_s   = ({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd2;
        out_en_s = !rst && !out_empty && room_s && payload_st_s;
    end

    // Two-entry skid FIFO, entry 0 is always the head.
    always_comb begin
        skid0_s = skid0_r;
        skid1_s = skid1_r;
        occ_s   = occ_r;
        drop_s  = 1'b0;
        case (occ_r)
            2'd0: begin
                if (out_valid) begin
                    skid0_s = out_data;
                    occ_s   = 2'd1;
                end else begin
                    occ_s = 2'd0;
                end
            end
            2'd1: begin
                if (out_valid && pop_s) begin
                    skid0_s = out_data;
                end else if (out_valid) begin
                    skid1_s = out_data;
                    occ_s   = 2'd2;
                end else if (pop_s) begin
                    occ_s = 2'd0;
                end else begin
                    occ_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    skid0_s = skid1_r;
                    if (out_valid) begin
                        skid1_s = out_data;
                    end else begin
                        occ_s = 2'd1;
                    end
                end else begin
                    drop_s = out_valid;
                end
            end
            default: begin
                occ_s = 2'd0;
            end
        endcase
    end

    // Block sequencer, per-block statistics and end-of-block latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            skid0_r    <= {DW{1'b0}};
            skid1_r    <= {DW{1'b0}};
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            end_seen_r <= 1'b0;
            end_pend_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            sum_r      <= {DW{1'b0}};
            ovf_r      <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            skid0_r    <= skid0_s;
            skid1_r    <= skid1_s;
            occ_r      <= occ_s;
            inflight_r <= out_en_s;
            if (stray_s || drop_s) begin
                perr_r <= 1'b1;
            end
            if (pop_s) begin
                sum_r <= sum_fold(sum_r, skid0_r);
                if (cnt_r == CNT_MAX) begin
                    ovf_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (out_valid || (occ_r != 2'd0)) begin
                        state_r <= ST_DRAIN;
                    end else if ((end_seen_r || blk_end) && out_empty && !inflight_r) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    if (end_seen_r && out_empty && !inflight_r && !out_valid &&
                        (occ_r == 2'd0)) begin
                        state_r <= ST_TRL0;
                    end
                end
                ST_FLUSH: begin
                    // A late word still belongs to this block, so go back and emit it.
                    if (out_valid || (occ_r != 2'd0)) begin
                        state_r <= ST_DRAIN;
                    end else if (!inflight_r) begin
                        state_r <= ST_TRL0;
                    end
                end
                ST_TRL0: begin
                    if (hs_s) begin
                        state_r <= ST_TRL1;
                    end
                end
                ST_TRL1: begin
                    if (hs_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        sum_r   <= {DW{1'b0}};
                        ovf_r   <= 1'b0;
                        perr_r  <= stray_s || drop_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // End markers seen while a trailer is out are held for the next block.
            if ((state_r == ST_TRL1) && hs_s) begin
                end_seen_r <= end_pend_r || blk_end;
                end_pend_r <= 1'b0;
            end else if ((state_r == ST_TRL0) || (state_r == ST_TRL1)) begin
                if (blk_end) begin
                    end_pend_r <= 1'b1;
                end
            end else if (blk_end) begin
                end_seen_r <= 1'b1;
            end
        end
    end

    assign out_en  = out_en_s;
    assign m_valid = m_valid_s;
    assign m_data  = m_data_s;
    assign m_last  = m_last_s;
    assign busy    = (state_r != ST_IDLE) || (occ_r != 2'd0);

endmodule

// File: tb/tb_lz4_out_reader.sv
// Bench for lz4_out_reader: FIFO model on the pop side, stream monitor on the
// output, directed table, corner sequences and randomized blocks vs a frame model.
module tb_lz4_out_reader;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          out_empty;
    logic [DW-1:0] out_data = 32'd0;
    logic          out_valid = 1'b0;
    logic          blk_end;
    logic          m_ready;
    logic          out_en, m_valid, m_last, busy;
    logic [DW-1:0] m_data;
    logic          out_en2, m_valid2, m_last2, busy2;
    logic [DW-1:0] m_data2;

    always #5 clk = ~clk;

    lz4_out_reader #(.DW(32), .CNT_W(16), .TRAIL_TAG(8'hA5)) dut (
        .clk(clk), .rst(rst), .out_empty(out_empty), .out_data(out_data),
        .out_valid(out_valid), .out_en(out_en), .blk_end(blk_end),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy));

    // Narrow-counter copy, fed the same stimulus in lockstep.
    lz4_out_reader #(.DW(32), .CNT_W(4), .TRAIL_TAG(8'hA5)) dut4 (
        .clk(clk), .rst(rst), .out_empty(out_empty), .out_data(out_data),
        .out_valid(out_valid), .out_en(out_en2), .blk_end(blk_end),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
        .m_last(m_last2), .busy(busy2));

    // Compressor FIFO model: pops answered with data one cycle later.
    logic [DW-1:0] fmem [0:255];
    logic [7:0]    wr_ptr;
    logic [7:0]    rd_ptr = 8'd0;
    logic          en_q = 1'b0;
    assign out_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        out_valid <= 1'b0;
        if (en_q) begin
            out_data  <= fmem[rd_ptr];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Output monitor
    logic [DW:0]   got_q[$];
    logic [DW:0]   got2_q[$];
    int            last_cnt = 0, last2_cnt = 0, en_total = 0, hs_total = 0, lock_bad = 0;
    int            mon_checks = 0, mon_errors = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = 32'd0;

    always @(negedge clk) begin
        en_q = out_en && !rst;
        if (en_q) en_total++;
        if (!rst && (out_en2 !== out_en)) lock_bad++;
        if (!rst && m_valid && m_ready) begin
            got_q.push_back({m_last, m_data});
            hs_total++;
            if (m_last) last_cnt++;
        end
        if (!rst && m_valid2 && m_ready) begin
            got2_q.push_back({m_last2, m_data2});
            if (m_last2) last2_cnt++;
        end
        if (!rst && stall_prev) begin
            mon_checks++;
            if (!m_valid || (m_data !== stall_data)) begin
                mon_errors++;
                $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                         m_valid, m_data, stall_data);
            end
        end
        stall_prev = !rst && m_valid && !m_ready;
        stall_data = m_data;
    end

    typedef struct {
        int            n;
        logic [3:0][31:0] w;
        int            rmode;
        logic [31:0]   t0;
        logic [31:0]   t1;
    } vec_t;

    int          checks = 0, errors = 0;
    int          cyc = 0, rmode = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] exp2_q[$];
    logic [DW-1:0] blk_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       m_ready = (($urandom % 4) != 0);
            3:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    endtask

    task automatic push(input logic [DW-1:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic pulse_end();
        blk_end = 1'b1;
        tick();
        blk_end = 1'b0;
    endtask

    // Frame model: words, {tag, perr, 0, ovf, count}, XOR of words (last).
    task automatic model_frame(input int cw, input bit second);
        logic [DW-1:0] sum;
        int            mx, cnt;
        logic [15:0]   c16;
        sum = 32'd0;
        mx  = (1 << cw) - 1;
        foreach (blk_q[i]) begin
            if (second) exp2_q.push_back({1'b0, blk_q[i]});
            else        exp_q.push_back({1'b0, blk_q[i]});
            sum = sum ^ blk_q[i];
        end
        cnt = (blk_q.size() > mx) ? mx : blk_q.size();
        c16 = cnt[15:0];
        if (second) begin
            exp2_q.push_back({1'b0, 8'hA5, 1'b0, 6'b000000, (blk_q.size() > mx), c16});
            exp2_q.push_back({1'b1, sum});
        end else begin
            exp_q.push_back({1'b0, 8'hA5, 1'b0, 6'b000000, (blk_q.size() > mx), c16});
            exp_q.push_back({1'b1, sum});
        end
    endtask

    task automatic wait_frames(input string name, input int t1, input int t2);
        int k;
        k = 0;
        while (((last_cnt < t1) || (last2_cnt < t2)) && (k < 400)) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d frames, required %0d", name, last_cnt, t1);
        end
    endtask

    task automatic cmp_stream(input string name, input bit use2, input int base);
        int n, ne;
        n  = use2 ? got2_q.size() : got_q.size();
        ne = use2 ? exp2_q.size() : exp_q.size();
        chk({name, "_len"}, 64'(n - base), 64'(ne));
        for (int i = 0; i < ne; i++) begin
            if (base + i < n) begin
                if (use2) chk($sformatf("%s[%0d]", name, i), 64'(got2_q[base + i]), 64'(exp2_q[i]));
                else      chk($sformatf("%s[%0d]", name, i), 64'(got_q[base + i]), 64'(exp_q[i]));
            end
        end
    endtask

    initial begin
        vec_t tbl[3];
        int   b1, b2, l1, l2, eb, hb, mxd, d, k, n;

        tbl[0].n = 4; tbl[0].w = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
        tbl[0].rmode = 0; tbl[0].t0 = 32'hA5000004; tbl[0].t1 = 32'hFFFFFFFF;
        tbl[1].n = 4; tbl[1].w = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
        tbl[1].rmode = 1; tbl[1].t0 = 32'hA5000004; tbl[1].t1 = 32'hFFFFFFFF;
        tbl[2].n = 0; tbl[2].w = {32'd0, 32'd0, 32'd0, 32'd0};
        tbl[2].rmode = 0; tbl[2].t0 = 32'hA5000000; tbl[2].t1 = 32'h00000000;

        wr_ptr = 8'd0; rst = 1'b1; blk_end = 1'b0; m_ready = 1'b0; rmode = 0;
        repeat (3) tick();
        chk("rst_out_en", 64'(out_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int v = 0; v < 3; v++) begin
            rmode = tbl[v].rmode;
            b1 = got_q.size(); l1 = last_cnt; eb = en_total; hb = hs_total; mxd = 0;
            exp_q.delete();
            for (int i = 0; i < tbl[v].n; i++) begin
                push(tbl[v].w[i]);
                exp_q.push_back({1'b0, tbl[v].w[i]});
            end
            exp_q.push_back({1'b0, tbl[v].t0});
            exp_q.push_back({1'b1, tbl[v].t1});
            tick();
            pulse_end();
            k = 0;
            while ((last_cnt < l1 + 1) && (k < 400)) begin
                d = (en_total - eb) - (hs_total - hb);
                if (d > mxd) mxd = d;
                tick();
                k++;
            end
            if (k >= 400) begin
                checks++; errors++;
                $display("FAIL vec%0d_timeout: got %0d frames, required %0d", v, last_cnt - l1, 1);
            end
            cmp_stream($sformatf("vec%0d", v), 1'b0, b1);
            chk($sformatf("vec%0d_pops", v), 64'(en_total - eb), 64'(tbl[v].n));
            chk($sformatf("vec%0d_outstanding_le2", v), 64'(mxd > 2), 64'd0);
            rmode = 0;
            repeat (3) tick();
        end

        // Back-to-back blocks, second end marker during the first trailer
        rmode = 0;
        b1 = got_q.size(); l1 = last_cnt; eb = en_total;
        exp_q.delete();
        blk_q = '{32'd1, 32'd2, 32'd3}; model_frame(16, 1'b0);
        blk_q = '{32'd5, 32'd6, 32'd7}; model_frame(16, 1'b0);
        push(32'd1); push(32'd2); push(32'd3);
        tick();
        pulse_end();
        k = 0;
        while (!(m_valid && (m_data == 32'hA5000003)) && (k < 400)) begin
            tick();
            k++;
        end
        chk("b2b_trl0_seen", 64'(k < 400), 64'd1);
        push(32'd5); push(32'd6); push(32'd7);
        pulse_end();
        wait_frames("b2b", l1 + 2, 0);
        cmp_stream("b2b", 1'b0, b1);
        chk("b2b_pops", 64'(en_total - eb), 64'd6);
        repeat (3) tick();

        // Count saturation on the narrow-counter instance
        b1 = got_q.size(); b2 = got2_q.size(); l1 = last_cnt; l2 = last2_cnt;
        exp_q.delete(); exp2_q.delete(); blk_q.delete();
        for (int i = 0; i < 17; i++) begin
            push(32'd1);
            blk_q.push_back(32'd1);
        end
        model_frame(16, 1'b0);
        model_frame(4, 1'b1);
        tick();
        pulse_end();
        wait_frames("sat", l1 + 1, l2 + 1);
        cmp_stream("sat16", 1'b0, b1);
        cmp_stream("sat4", 1'b1, b2);
        if (got2_q.size() >= b2 + 19) begin
            chk("sat4_trl0", 64'(got2_q[b2 + 17]), {31'd0, 1'b0, 32'hA501000F});
            chk("sat4_trl1", 64'(got2_q[b2 + 18]), {31'd0, 1'b1, 32'h00000001});
        end else begin
            chk("sat4_frame_len", 64'(got2_q.size() - b2), 64'd19);
        end
        repeat (3) tick();

        // Reset with two words parked in the skid
        rmode = 3;
        push(32'hDEAD0001); push(32'hDEAD0002);
        repeat (6) tick();
        chk("prerst_m_valid", 64'(m_valid), 64'd1);
        chk("prerst_m_data", 64'(m_data), 64'hDEAD0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("postrst_m_valid", 64'(m_valid), 64'd0);
        chk("postrst_out_en", 64'(out_en), 64'd0);
        chk("postrst_busy", 64'(busy), 64'd0);
        rmode = 0;
        tick();
        b1 = got_q.size(); l1 = last_cnt;
        exp_q.delete();
        blk_q = '{32'hCAFE0001}; model_frame(16, 1'b0);
        push(32'hCAFE0001);
        tick();
        pulse_end();
        wait_frames("postrst_blk", l1 + 1, 0);
        cmp_stream("postrst_blk", 1'b0, b1);
        repeat (3) tick();

        // Randomized blocks with random back-pressure
        for (int r = 0; r < 10; r++) begin
            rmode = 2;
            b1 = got_q.size(); b2 = got2_q.size(); l1 = last_cnt; l2 = last2_cnt;
            exp_q.delete(); exp2_q.delete(); blk_q.delete();
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                blk_q.push_back($urandom);
                push(blk_q[i]);
            end
            model_frame(16, 1'b0);
            model_frame(4, 1'b1);
            tick();
            pulse_end();
            wait_frames($sformatf("rnd%0d", r), l1 + 1, l2 + 1);
            cmp_stream($sformatf("rnd%0d", r), 1'b0, b1);
            cmp_stream($sformatf("rnd%0d_cw4", r), 1'b1, b2);
            rmode = 0;
            repeat (2) tick();
        end

        chk("lockstep_out_en", 64'(lock_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
